// File: rtl/match_scheduler.sv
// match_scheduler
//
// Sequences a two-player, multi-round shooting match: prep and play
// countdowns, the 1-second tick, per-player BCD scores, round alternation
// and the winner decision. It also decodes the four display digits for the
// seven-segment scanner.
//
// Parameters:
//   TICK_DIV  clk cycles per one-second tick (>= 2)
//   PREP_SEC  prep countdown length in seconds (1..99)
//   PLAY_SEC  play countdown length in seconds (1..99)
//   ROUNDS    total rounds, even, 2..16; P1 plays even rounds, P2 odd rounds
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   start, goal, abort  single-cycle pulses (already debounced)
//   dig0..dig3          display codes: 0-9 digit, 10 dash, 11 blank
//   player              active player (0 = P1, 1 = P2)
//   busy                high in PREP and PLAY
//   winner              01 = P1, 10 = P2, 11 = tie, 00 = no result
//
// Build option:
//   FINAL_BONUS_EN  when defined, a goal scored while the play timer shows
//                   5 seconds or less adds 2 points (still saturating at 99).

module match_scheduler #(
    parameter int TICK_DIV = 100000000,
    parameter int PREP_SEC = 3,
    parameter int PLAY_SEC = 30,
    parameter int ROUNDS   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       goal,
    input  logic       abort,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       player,
    output logic       busy,
    output logic [1:0] winner
);

    localparam int             CNT_W      = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0]     PREP_BCD   = {4'(PREP_SEC / 10), 4'(PREP_SEC % 10)};
    localparam logic [7:0]     PLAY_BCD   = {4'(PLAY_SEC / 10), 4'(PLAY_SEC % 10)};
    localparam logic [3:0]     LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [3:0]     CODE_DASH  = 4'd10;
    localparam logic [3:0]     CODE_BLANK = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_PLAY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]       timer_q, timer_d;
    logic [3:0]       round_q, round_d;
    logic [7:0]       p1_score_q, p1_score_d;
    logic [7:0]       p2_score_q, p2_score_d;

    logic             counting;
    logic             tick;
    logic             timer_is_one;
    logic             new_match;
    logic [7:0]       active_score;
    logic [7:0]       bumped_score;

    // Two-digit packed BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign counting     = (state_q == S_PREP) || (state_q == S_PLAY);
    assign tick         = counting && (tick_cnt_q == TICK_LAST);
    assign timer_is_one = (timer_q == 8'h01);
    assign player       = round_q[0];

    // A fresh match starts from IDLE or DONE; abort never reaches PREP.
    assign new_match = ((state_q == S_IDLE) || (state_q == S_DONE)) && (state_d == S_PREP);

    always_comb begin
        active_score = round_q[0] ? p2_score_q : p1_score_q;
`ifdef FINAL_BONUS_EN
        if ((timer_q[7:4] == 4'd0) && (timer_q[3:0] <= 4'd5)) begin
            bumped_score = bcd_inc(bcd_inc(active_score));
        end else begin
            bumped_score = bcd_inc(active_score);
        end
`else
        bumped_score = bcd_inc(active_score);
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything, including start.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) state_d = S_PREP;
                S_PREP:         if (tick && timer_is_one) state_d = S_PLAY;
                S_PLAY: begin
                    if (tick && timer_is_one) begin
                        state_d = (round_q < LAST_ROUND) ? S_PREP : S_DONE;
                    end
                end
                default:        state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values: tick counter, timer, round and scores.
    always_comb begin
        tick_cnt_d = '0;
        timer_d    = timer_q;
        round_d    = round_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;

        // The counter restarts on every state change so each phase is whole seconds.
        if (counting && (state_d == state_q) && !tick) begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end

        if (abort) begin
            timer_d    = 8'h00;
            round_d    = 4'd0;
            p1_score_d = 8'h00;
            p2_score_d = 8'h00;
        end else begin
            if (state_d == S_PREP && state_q != S_PREP) begin
                timer_d = PREP_BCD;
            end else if (state_d == S_PLAY && state_q != S_PLAY) begin
                timer_d = PLAY_BCD;
            end else if (tick) begin
                if (timer_q[3:0] == 4'd0) begin
                    timer_d = {timer_q[7:4] - 4'd1, 4'd9};
                end else begin
                    timer_d = {timer_q[7:4], timer_q[3:0] - 4'd1};
                end
            end

            if (new_match) begin
                round_d    = 4'd0;
                p1_score_d = 8'h00;
                p2_score_d = 8'h00;
            end else begin
                if (state_q == S_PLAY && state_d == S_PREP) begin
                    round_d = round_q + 4'd1;
                end
                // A goal on the final tick still belongs to the ending player.
                if (state_q == S_PLAY && goal) begin
                    if (round_q[0]) begin
                        p2_score_d = bumped_score;
                    end else begin
                        p1_score_d = bumped_score;
                    end
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            timer_q    <= 8'h00;
            round_q    <= 4'd0;
            p1_score_q <= 8'h00;
            p2_score_q <= 8'h00;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            timer_q    <= timer_d;
            round_q    <= round_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
        end
    end

    // Output decode; packed BCD compares correctly as plain binary.
    always_comb begin
        dig0   = CODE_DASH;
        dig1   = CODE_DASH;
        dig2   = CODE_DASH;
        dig3   = CODE_DASH;
        busy   = 1'b0;
        winner = 2'b00;
        case (state_q)
            S_PREP: begin
                dig0 = CODE_BLANK;
                dig1 = CODE_BLANK;
                dig2 = timer_q[3:0];
                dig3 = timer_q[7:4];
                busy = 1'b1;
            end
            S_PLAY: begin
                dig0 = active_score[3:0];
                dig1 = active_score[7:4];
                dig2 = timer_q[3:0];
                dig3 = timer_q[7:4];
                busy = 1'b1;
            end
            S_DONE: begin
                dig0 = p2_score_q[3:0];
                dig1 = p2_score_q[7:4];
                dig2 = p1_score_q[3:0];
                dig3 = p1_score_q[7:4];
                if (p1_score_q > p2_score_q) begin
                    winner = 2'b01;
                end else if (p2_score_q > p1_score_q) begin
                    winner = 2'b10;
                end else begin
                    winner = 2'b11;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_match_scheduler.sv
// tb_match_scheduler
//
// Directed bench for match_scheduler. The main instance runs with
// TICK_DIV=4, PREP_SEC=3, PLAY_SEC=5, ROUNDS=2. A second instance with a
// slower tick (TICK_DIV=64, PLAY_SEC=2) gives a PLAY phase long enough to
// push a score into saturation. Display words are {dig3,dig2,dig1,dig0}.
// Building with FINAL_BONUS_EN scales the expected goal value to 2.

`timescale 1ns/1ps

module tb_match_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, goal, abort;
    logic       start2, goal2, abort2;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic [3:0] satDig0, satDig1, satDig2, satDig3;
    logic       player, busy, satPlayer, satBusy;
    logic [1:0] winner, satWinner;
    logic [15:0] disp, satDisp;

    int testsRun    = 0;
    int testsFailed = 0;

`ifdef FINAL_BONUS_EN
    localparam int GINC = 2;
`else
    localparam int GINC = 1;
`endif

    match_scheduler #(
        .TICK_DIV(4), .PREP_SEC(3), .PLAY_SEC(5), .ROUNDS(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .goal(goal), .abort(abort),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .player(player), .busy(busy), .winner(winner)
    );

    match_scheduler #(
        .TICK_DIV(64), .PREP_SEC(1), .PLAY_SEC(2), .ROUNDS(2)
    ) dutSat (
        .clk(clk), .rst(rst), .start(start2), .goal(goal2), .abort(abort2),
        .dig0(satDig0), .dig1(satDig1), .dig2(satDig2), .dig3(satDig3),
        .player(satPlayer), .busy(satBusy), .winner(satWinner)
    );

    assign disp    = {dig3, dig2, dig1, dig0};
    assign satDisp = {satDig3, satDig2, satDig1, satDig0};

    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Score after n goals, including bonus scaling and saturation.
    function automatic int sc(input int n);
        return (n * GINC > 99) ? 99 : n * GINC;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one-cycle pulses into the main instance; returns 1ns after the edge.
    task automatic applyStimulus(input logic s, input logic g, input logic a);
        start = s;
        goal  = g;
        abort = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        goal  = 1'b0;
        abort = 1'b0;
    endtask

    task automatic pulseSat(input logic s, input logic g);
        start2 = s;
        goal2  = g;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        goal2  = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; goal = 1'b0; abort = 1'b0;
        start2 = 1'b0; goal2 = 1'b0; abort2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset and idle behaviour.
        checkOutput("reset_disp", disp, 16'hAAAA);
        checkOutput("reset_busy", 16'(busy), 16'h0);
        checkOutput("reset_winner", 16'(winner), 16'h0);
        checkOutput("reset_player", 16'(player), 16'h0);
        checkOutput("sat_reset_disp", satDisp, 16'hAAAA);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("idle_goal_disp", disp, 16'hAAAA);

        // Match 1: prep countdown, then P1 scores 3 (last one on the final tick), P2 scores 1.
        applyStimulus(1, 0, 0);
        checkOutput("prep_03", disp, 16'h03BB);
        checkOutput("prep_busy", 16'(busy), 16'h1);
        checkOutput("prep_player", 16'(player), 16'h0);
        applyStimulus(0, 1, 0);
        waitCycles(3);
        checkOutput("prep_02", disp, 16'h02BB);
        waitCycles(4);
        checkOutput("prep_01", disp, 16'h01BB);
        waitCycles(3);
        checkOutput("prep_last_cycle", disp, 16'h01BB);
        waitCycles(1);
        checkOutput("play_entry", disp, 16'h0500);
        checkOutput("play_winner", 16'(winner), 16'h0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("r0_two_goals", disp, {8'h05, bcd2(sc(2))});
        waitCycles(17);
        checkOutput("r0_final_sec", disp, {8'h01, bcd2(sc(2))});
        applyStimulus(0, 1, 0);
        checkOutput("r1_prep", disp, 16'h03BB);
        checkOutput("r1_prep_player", 16'(player), 16'h1);
        waitCycles(12);
        checkOutput("r1_play", disp, 16'h0500);
        applyStimulus(0, 1, 0);
        checkOutput("r1_goal", disp, {8'h05, bcd2(sc(1))});
        waitCycles(19);
        checkOutput("done_disp", disp, {bcd2(sc(3)), bcd2(sc(1))});
        checkOutput("done_winner", 16'(winner), 16'h1);
        checkOutput("done_busy", 16'(busy), 16'h0);

        // Match 2: tie at 2 goals each.
        applyStimulus(1, 0, 0);
        checkOutput("rematch_prep", disp, 16'h03BB);
        checkOutput("rematch_player", 16'(player), 16'h0);
        waitCycles(12);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("tie_r0", disp, {8'h05, bcd2(sc(2))});
        waitCycles(18);
        waitCycles(12);
        checkOutput("tie_r1_entry", disp, 16'h0500);
        checkOutput("tie_r1_player", 16'(player), 16'h1);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        waitCycles(18);
        checkOutput("tie_done", disp, {bcd2(sc(2)), bcd2(sc(2))});
        checkOutput("tie_winner", 16'(winner), 16'h3);

        // Restart from DONE clears scores; abort with start returns to IDLE.
        applyStimulus(1, 0, 0);
        checkOutput("restart_prep", disp, 16'h03BB);
        checkOutput("restart_player", 16'(player), 16'h0);
        checkOutput("restart_winner", 16'(winner), 16'h0);
        waitCycles(12);
        checkOutput("restart_play_cleared", disp, 16'h0500);
        applyStimulus(0, 1, 0);
        applyStimulus(1, 0, 1);
        checkOutput("abort_disp", disp, 16'hAAAA);
        checkOutput("abort_busy", 16'(busy), 16'h0);
        checkOutput("abort_winner", 16'(winner), 16'h0);
        waitCycles(4);
        checkOutput("abort_stays_idle", disp, 16'hAAAA);

        // Saturation on the slow instance.
        pulseSat(1, 0);
        checkOutput("sat_prep", satDisp, 16'h01BB);
        waitCycles(63);
        checkOutput("sat_prep_last", satDisp, 16'h01BB);
        waitCycles(1);
        checkOutput("sat_play", satDisp, 16'h0200);
        for (int i = 0; i < 98; i++) pulseSat(0, 1);
        checkOutput("sat_98", satDisp, {8'h01, bcd2(sc(98))});
        pulseSat(0, 1);
        pulseSat(0, 1);
        checkOutput("sat_99", satDisp, 16'h0199);

        // Asynchronous reset in the middle of round 1 PLAY.
        applyStimulus(1, 0, 0);
        waitCycles(12);
        waitCycles(20);
        waitCycles(12);
        applyStimulus(0, 1, 0);
        checkOutput("pre_rst_disp", disp, {8'h05, bcd2(sc(1))});
        checkOutput("pre_rst_player", 16'(player), 16'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_disp", disp, 16'hAAAA);
        checkOutput("rst_busy", 16'(busy), 16'h0);
        checkOutput("rst_player", 16'(player), 16'h0);
        checkOutput("rst_winner", 16'(winner), 16'h0);
        checkOutput("rst_sat_disp", satDisp, 16'hAAAA);
        @(negedge clk);
        rst = 1'b0;
        waitCycles(5);
        checkOutput("post_rst_idle", disp, 16'hAAAA);
        checkOutput("post_rst_busy", 16'(busy), 16'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/match_scheduler.md
# match_scheduler

Sequences a two-player, multi-round shooting match on the shared hoop sensor and score datapath. It replaces the single-player game FSM. The block owns the prep and play countdowns, the 1-second tick, the per-player BCD score registers, round alternation and winner decision. It drives the four display digits consumed by the seven-segment scanner. `start`, `goal` and `abort` arrive already debounced and one-pulsed, each high for 1 `clk` cycle.

## Interface
Parameters:
- `TICK_DIV`, default 100000000: `clk` cycles per second tick; must be ≥2.
- `PREP_SEC`, default 3: prep countdown length in seconds; range 1..99.
- `PLAY_SEC`, default 30: play countdown length in seconds; range 1..99.
- `ROUNDS`, default 4: total rounds; must be even, range 2..16. Player 1 plays even rounds, player 2 plays odd rounds.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  pulse; begins a match.
- `goal`  in  1  pulse; basket scored.
- `abort`  in  1  pulse; cancels the match.
- `dig0`..`dig3`  out  4 each  display codes: 0–9 digit, 10 dash, 11 blank.
- `player`  out  1  active player: 0 = P1, 1 = P2.
- `busy`  out  1  high in PREP and PLAY.
- `winner`  out  2  01 = P1, 10 = P2, 11 = tie, 00 = no result.

## Operation
- States and transitions:
  - IDLE: `start` → PREP; clears both scores and sets round=0.
  - PREP: on a tick with timer==1 → PLAY; loads timer=PLAY_SEC.
  - PLAY: on a tick with timer==1 → PREP if round<ROUNDS-1 (round+1, timer=PREP_SEC), else → DONE.
  - DONE: `start` behaves as in IDLE.
- `abort` in any state → IDLE. Scores are cleared and `winner`=00.
- Entering PREP loads timer=PREP_SEC.
- Timer is two BCD digits (tens, ones). Decrement borrows ones 0→9 and tens−1.
- Tick counter: runs 0..TICK_DIV-1 only in PREP and PLAY. It clears to 0 on every state entry. The tick pulse is the cycle with count==TICK_DIV-1.
- Scores: two BCD digits per player. A `goal` in PLAY adds 1 to the active player's score. The score saturates at 99. A `goal` outside PLAY is ignored.
- Display codes:
  - IDLE: all digits 10.
  - PREP: dig0=dig1=11; dig2=timer ones; dig3=timer tens.
  - PLAY: dig0/dig1 = active player's score ones/tens; dig2/dig3 = timer ones/tens.
  - DONE: dig0/dig1 = P2 score ones/tens; dig2/dig3 = P1 score ones/tens.
- `player` = round[0].
- `winner` is nonzero only in DONE. It compares the P1 and P2 scores as BCD values (tens first).
- Reset values: state IDLE, round 0, timer 00, scores 00, tick count 0, `dig0`..`dig3`=10, `player`=0, `busy`=0, `winner`=00.

## Timing
- All state lives in registers. Outputs are combinational decodes of those registers, so each output reflects an event on the edge after that event's pulse.
- `start` → PREP visible 1 cycle later. The first tick arrives TICK_DIV cycles after PREP entry.
- Each PREP phase lasts exactly PREP_SEC×TICK_DIV cycles. Each PLAY phase lasts exactly PLAY_SEC×TICK_DIV cycles.
- Simultaneous events:
  - `abort` with `start`: `abort` wins.
  - `goal` on the final PLAY tick: the goal is counted for the ending player.
  - `start` during PREP or PLAY: ignored.
- `rst` asserted mid-match: immediate asynchronous return to reset values. The match does not resume.

## Configuration
- `FINAL_BONUS_EN` defined: a `goal` in PLAY while timer ≤ 5 adds 2 instead of 1, still saturating at 99. A score of 98 plus a bonus goal gives 99.
- `FINAL_BONUS_EN` undefined: every goal adds 1. No bonus logic is synthesized.

## Test plan
Bench parameters: TICK_DIV=4, PREP_SEC=3, PLAY_SEC=5, ROUNDS=2.
- Reset then idle: `dig0`..`dig3`=10, `winner`=00, `busy`=0. `goal` pulses leave the scores at 0.
- `start`: PREP shows dig3:dig2 = 03, then 02 and 01 at 4-cycle spacing. PLAY with timer 05 is entered 12 cycles after PREP entry.
- 3 goals in round 0 and 1 goal in round 1 → DONE with dig3:dig2=03, dig1:dig0=01, `winner`=01. With `FINAL_BONUS_EN` defined and all goals in the final seconds: 06/02, `winner`=01.
- Equal scores (2 and 2) → `winner`=11. Then `start` clears both scores and the match re-enters PREP with round 0, `player`=0.
- `goal` on the final-tick cycle of round 0 is counted. `abort` with `start` in PLAY → IDLE with all digits 10.
- 100 goals in one PLAY phase (TICK_DIV raised so they fit) → score saturates at 99. `rst` pulse mid-PLAY → all outputs return to reset values on the same edge.
